// File: rtl/index_to_vector_builder.sv
// Collects a packet of bit indices into a bit vector and hands the finished
// vector to a consumer over a valid/ready handshake, flagging out-of-range indices.
module index_to_vector_builder #(
    parameter int unsigned VECTOR_LENGTH   = 8,
    parameter int unsigned MAX_INPUT_WIDTH = 16
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic [MAX_INPUT_WIDTH-1:0] index_in,
    input  logic                       index_valid_in,
    input  logic                       index_last_in,
    output logic                       index_ready_out,
    output logic [VECTOR_LENGTH-1:0]   vector_out,
    output logic                       vector_valid_out,
    input  logic                       vector_ready_in,
    output logic                       range_error_out
);

    // Compare width wide enough for both the index and the vector length.
    localparam int unsigned CMP_W = (MAX_INPUT_WIDTH > 32) ? MAX_INPUT_WIDTH : 32;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [VECTOR_LENGTH-1:0]   r_accum;
    logic [VECTOR_LENGTH-1:0]   w_accum_nxt;
    logic                       r_error;
    logic                       w_error_nxt;
    logic                       r_index_ready;
    logic                       w_index_ready_nxt;
    logic                       r_vector_valid;
    logic                       w_vector_valid_nxt;

    logic                       w_beat;
    logic                       w_take;
    logic                       w_in_range;
    logic [VECTOR_LENGTH-1:0]   w_onehot;

    assign w_beat     = index_valid_in & r_index_ready;
    assign w_take     = r_vector_valid & vector_ready_in;
    assign w_in_range = CMP_W'(index_in) < CMP_W'(VECTOR_LENGTH);
    assign w_onehot   = VECTOR_LENGTH'(1) << index_in;

    // Next-state, accumulator and handshake-output decode.
    always_comb begin
        w_state_nxt        = r_state;
        w_accum_nxt        = r_accum;
        w_error_nxt        = r_error;
        w_index_ready_nxt  = 1'b1;
        w_vector_valid_nxt = 1'b0;

        case (r_state)
            ST_COLLECT: begin
                if (w_beat) begin
                    if (w_in_range) begin
                        w_accum_nxt = r_accum | w_onehot;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                    if (index_last_in) begin
                        w_state_nxt = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                if (w_take) begin
                    w_state_nxt = ST_COLLECT;
                    w_accum_nxt = '0;
                    w_error_nxt = 1'b0;
                end
            end
        endcase

        w_index_ready_nxt  = (w_state_nxt == ST_COLLECT);
        w_vector_valid_nxt = (w_state_nxt == ST_PRESENT);
    end

    // State and output registers; reset drops any packet in flight.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state        <= ST_COLLECT;
            r_accum        <= '0;
            r_error        <= 1'b0;
            r_index_ready  <= 1'b1;
            r_vector_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_accum        <= w_accum_nxt;
            r_error        <= w_error_nxt;
            r_index_ready  <= w_index_ready_nxt;
            r_vector_valid <= w_vector_valid_nxt;
        end
    end

    assign index_ready_out  = r_index_ready;
    assign vector_valid_out = r_vector_valid;
    assign vector_out       = r_accum;
    assign range_error_out  = r_error;

endmodule

// File: doc/index_to_vector_builder.md
INDEX_TO_VECTOR_BUILDER -- requirements
Module: index_to_vector_builder

Interface
REQ-001 SHALL have parameter VECTOR_LENGTH, default 8, meaning the width of the built vector in bits.
REQ-002 SHALL have parameter MAX_INPUT_WIDTH, default 16, meaning the width of the index input.
REQ-003 SHALL have port clk_in  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset_in  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port index_in  input  MAX_INPUT_WIDTH  bit index to set in the vector being built.
REQ-006 SHALL have port index_valid_in  input  1  index_in and index_last_in are valid.
REQ-007 SHALL have port index_last_in  input  1  the current index is the final index of the packet.
REQ-008 SHALL have port index_ready_out  output  1  the block accepts an index this cycle.
REQ-009 SHALL have port vector_out  output  VECTOR_LENGTH  completed vector.
REQ-010 SHALL have port vector_valid_out  output  1  vector_out and range_error_out are valid.
REQ-011 SHALL have port vector_ready_in  input  1  the consumer takes the vector this cycle.
REQ-012 SHALL have port range_error_out  output  1  the packet contained an index >= VECTOR_LENGTH.

Function
REQ-013 SHALL implement a two-state FSM: COLLECT and PRESENT.
REQ-014 SHALL treat an index beat as accepted when index_valid_in and index_ready_out are both high.
REQ-015 SHALL treat the vector as taken when vector_valid_out and vector_ready_in are both high.
REQ-016 In COLLECT, SHALL drive index_ready_out=1 and vector_valid_out=0.
REQ-017 In PRESENT, SHALL drive index_ready_out=0 and vector_valid_out=1.
REQ-018 On each accepted beat with index_in < VECTOR_LENGTH, SHALL set accumulator bit index_in at the next edge.
REQ-019 SHALL leave all other accumulator bits unchanged on an accepted beat.
REQ-020 SHALL treat repeated indices within a packet as idempotent.
REQ-021 On an accepted beat with index_in >= VECTOR_LENGTH, SHALL modify no accumulator bit.
REQ-022 SHALL compare the full MAX_INPUT_WIDTH value, with no truncation, when deciding whether an index is in range.
REQ-023 On an accepted beat with index_in >= VECTOR_LENGTH, SHALL set a sticky packet error flag.
REQ-024 On an accepted beat with index_last_in=1, SHALL transition COLLECT->PRESENT at the next edge.
REQ-025 On that transition, vector_out SHALL include that final beat's bit.
REQ-026 On that transition, range_error_out SHALL include that final beat's error.
REQ-027 Latency SHALL be one cycle, from the last accepted beat to vector_valid_out=1.
REQ-028 In PRESENT, vector_out and range_error_out SHALL hold stable until taken.
REQ-029 In PRESENT, SHALL ignore index_valid_in entirely.
REQ-030 On a take, SHALL transition PRESENT->COLLECT at the next edge.
REQ-031 On a take, SHALL clear the accumulator and the error flag to 0 at the next edge.
REQ-032 SHALL therefore support a sustained rate of one packet per (beats+1) cycles.
REQ-033 In COLLECT, vector_out SHALL show the partial accumulator; consumers SHALL ignore it while vector_valid_out=0.
REQ-034 SHALL leave state unchanged on a COLLECT cycle with index_valid_in=0 and on a PRESENT cycle with vector_ready_in=0.
REQ-035 SHALL provide no empty-packet mechanism; every packet carries at least one beat.
REQ-036 SHALL make index_ready_out depend only on state, with no combinational path from vector_ready_in.

Reset
REQ-037 While reset_in=1 at an edge, SHALL enter COLLECT regardless of current state, including mid-packet and PRESENT.
REQ-038 While reset_in=1 at an edge, SHALL clear the accumulator, vector_out and the error flag to all zeros.
REQ-039 Reset values SHALL be index_ready_out=1 (COLLECT), vector_valid_out=0, vector_out=0 and range_error_out=0.
REQ-040 SHALL drop any partially collected or unpresented packet on reset, with no output.
REQ-041 SHALL discard a beat presented in the same cycle as reset_in=1.

Verification (VECTOR_LENGTH=8)
REQ-042 Bench SHALL drive beats 1, 5, 7(last) with vector_ready_in=1 -> vector_valid_out=1 one cycle after the last beat, vector_out=8'b1010_0010, range_error_out=0, then COLLECT.
REQ-043 Bench SHALL drive a single beat 0(last) with vector_ready_in=0 for 4 cycles -> vector_out=8'h01 held stable and index_ready_out=0 throughout; index_valid_in pulses during the stall are ignored.
REQ-044 Bench SHALL drive beats 3, 3, 9, 2(last) -> vector_out=8'h0C, range_error_out=1; the next packet 6(last) -> 8'h40 with range_error_out=0.
REQ-045 Bench SHALL drive index_in=16'h0100 (low bits 0) as last -> vector_out=8'h00, range_error_out=1.
REQ-046 Bench SHALL pulse reset_in after beats 4, 6 and before last, then send 1(last) -> vector_out=8'h02.
REQ-047 Bench SHALL pulse reset_in in PRESENT -> vector_valid_out=0 next cycle and the accumulator reads 0.
